// File: rtl/logic_cluster_if.sv
// rtl/logic_cluster_if.sv - serial configuration port bundle for logic_cluster
interface logic_cluster_if;
  logic prog_en;
  logic prog_in;
  logic prog_out;
  logic prog_done;
  logic prog_err;
  logic cfg_valid;

  modport master (
    output prog_en, prog_in,
    input  prog_out, prog_done, prog_err, cfg_valid
  );

  modport slave (
    input  prog_en, prog_in,
    output prog_out, prog_done, prog_err, cfg_valid
  );
endinterface

// File: rtl/logic_cluster.sv
// rtl/logic_cluster.sv - NUM_LE x (LUT_K-LUT + FF) cluster with serial shadow/active config
// Optional feature macro: CFG_PARITY_EN (trailing even-parity bit on the config stream)
module logic_cluster #(
  parameter int NUM_LE = 4,
  parameter int LUT_K  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  logic_cluster_if.slave          prog,
  input  logic [NUM_LE*LUT_K-1:0] in,
  output logic [NUM_LE-1:0]       out
);
  localparam int LUT_BITS = 2 ** LUT_K;
  localparam int LE_BITS  = LUT_BITS + 3;
  localparam int CFG_BITS = NUM_LE * LE_BITS;
`ifdef CFG_PARITY_EN
  localparam int SH_BITS  = CFG_BITS + 1;
`else
  localparam int SH_BITS  = CFG_BITS;
`endif
  localparam int CNT_W    = $clog2(SH_BITS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]          state;
  logic [SH_BITS-1:0]  shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    bit_cnt;
  logic                cfg_valid;
  logic                prog_done;
  logic                prog_err;
  logic                cnt_full;
  logic                image_ok;

  assign cnt_full = (bit_cnt == CNT_W'(SH_BITS));
`ifdef CFG_PARITY_EN
  assign image_ok = cnt_full && !(^shadow);
`else
  assign image_ok = cnt_full;
`endif

  assign prog.prog_out  = shadow[SH_BITS-1];
  assign prog.prog_done = prog_done;
  assign prog.prog_err  = prog_err;
  assign prog.cfg_valid = cfg_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      active    <= '0;
      bit_cnt   <= '0;
      cfg_valid <= 1'b0;
      prog_done <= 1'b0;
      prog_err  <= 1'b0;
    end else begin
      prog_done <= 1'b0;
      prog_err  <= 1'b0;
      // The chain shifts in every state; only the SHIFT->COMMIT edge skips a bit.
      if (prog.prog_en)
        shadow <= {shadow[SH_BITS-2:0], prog.prog_in};

      case (state)
        IDLE: begin
          if (prog.prog_en) begin
            state   <= SHIFT;
            bit_cnt <= CNT_W'(1);
          end
        end
        SHIFT: begin
          if (!prog.prog_en)
            state <= COMMIT;
          else if (!cnt_full)
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
        COMMIT: begin
          if (image_ok) begin
            active    <= shadow[SH_BITS-1 -: CFG_BITS];
            cfg_valid <= 1'b1;
            prog_done <= 1'b1;
          end else begin
            prog_err  <= 1'b1;
          end
          state   <= prog.prog_en ? SHIFT : IDLE;
          bit_cnt <= prog.prog_en ? CNT_W'(1) : CNT_W'(0);
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    logic [LE_BITS-1:0]  c;
    logic [LUT_BITS-1:0] tt;
    logic [LUT_K-1:0]    lin;
    logic                lut_out;
    logic                ff_en;
    logic                ff_q;

    assign c  = active[i*LE_BITS +: LE_BITS];
    assign tt = c[LUT_BITS-1:0];

    always_comb begin
      lin = in[i*LUT_K +: LUT_K];
      if (c[LUT_BITS+1])
        lin[0] = ff_q;
    end

    assign lut_out = tt[lin];
    assign ff_en   = c[LUT_BITS] ? in[i*LUT_K + LUT_K - 1] : 1'b1;
    assign out[i]  = c[LUT_BITS+2] ? ff_q : lut_out;

    // Registers run only from a committed image and freeze while the chain is busy.
    always_ff @(posedge clk) begin
      if (rst)
        ff_q <= 1'b0;
      else if (state == IDLE && cfg_valid && ff_en)
        ff_q <= lut_out;
    end
  end
endmodule

// File: tb/tb_logic_cluster.sv
// tb/tb_logic_cluster.sv - directed scoreboard bench for two chained logic_cluster tiles
module tb_logic_cluster;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in0 = '0;
  logic [15:0] in1 = '0;
  logic [3:0]  out0;
  logic [3:0]  out1;

  logic_cluster_if if0 ();
  logic_cluster_if if1 ();

  assign if1.prog_en = if0.prog_en;
  assign if1.prog_in = if0.prog_out;

  logic_cluster #(.NUM_LE(4), .LUT_K(4)) u0 (
    .clk(clk), .rst(rst), .prog(if0), .in(in0), .out(out0)
  );
  logic_cluster #(.NUM_LE(4), .LUT_K(4)) u1 (
    .clk(clk), .rst(rst), .prog(if1), .in(in1), .out(out1)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_t;
  sb_t sbq[$];

  logic [75:0] img_a, img_b, img_c;

  function automatic logic [75:0] mk(input logic [18:0] l0, input logic [18:0] l1,
                                     input logic [18:0] l2, input logic [18:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [3:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [3:0] obs);
    sb_t e;
    chk("sb_nonempty", (sbq.size() != 0), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift data[n-1] first; returns just after the edge where prog_done/prog_err should pulse.
  task automatic load(input logic [151:0] data, input int n, input logic exp_ok, input string tag);
    for (int k = 1; k <= n; k++) begin
      if0.prog_en = 1'b1;
      if0.prog_in = data[n-k];
      tick();
      if (k == 76 || (k >= 76 && k == n))
        chk({tag, "_prog_out"}, if0.prog_out, data[n-(k-75)]);
    end
    if0.prog_en = 1'b0;
    if0.prog_in = 1'b0;
    tick();
    chk({tag, "_done_early"}, {if1.prog_done, if0.prog_done}, 2'b00);
    chk({tag, "_err_early"},  {if1.prog_err,  if0.prog_err},  2'b00);
    tick();
    chk({tag, "_done"}, {if1.prog_done, if0.prog_done}, {exp_ok, exp_ok});
    chk({tag, "_err"},  {if1.prog_err,  if0.prog_err},  {!exp_ok, !exp_ok});
  endtask

  initial begin
    if0.prog_en = 1'b0;
    if0.prog_in = 1'b0;
    img_a = mk({3'b000, 16'h8000}, {3'b110, 16'h5555}, {3'b000, 16'hFFFE}, 19'h0);
    img_b = mk({3'b000, 16'h0001}, 19'h0, 19'h0, 19'h0);
    img_c = mk({3'b000, 16'h6996}, 19'h0, 19'h0, {3'b101, 16'hFFFF});

    // Reset
    rst = 1'b1;
    in0 = 16'hFFFF;
    repeat (3) tick();
    sb_push("rst_out", 4'h0);
    sb_pop(out0);
    chk("rst_cfg_valid", if0.cfg_valid, 0);
    chk("rst_prog_done", if0.prog_done, 0);
    chk("rst_prog_err",  if0.prog_err,  0);
    chk("rst_prog_out",  if0.prog_out,  0);
    rst = 1'b0;
    in0 = '0;

    // First image: LE0 AND4, LE1 toggling FF, LE2 OR4
    load({76'h0, img_a}, 76, 1'b1, "load_a");
    chk("a_cfg_valid", if0.cfg_valid, 1);
    sb_push("a_tog0", 4'h0); sb_pop({3'b0, out0[1]});
    in0[3:0] = 4'hF; sb_push("a_and4_f", {3'b0, &in0[3:0]}); #1; sb_pop({3'b0, out0[0]});
    in0[3:0] = 4'hE; sb_push("a_and4_e", {3'b0, &in0[3:0]}); #1; sb_pop({3'b0, out0[0]});
    in0[11:8] = 4'h4; sb_push("a_or4", {3'b0, |in0[11:8]}); #1; sb_pop({3'b0, out0[2]});
    tick();
    chk("a_done_pulse", if0.prog_done, 0);
    sb_push("a_tog1", 4'h1); sb_pop({3'b0, out0[1]});
    tick();
    sb_push("a_tog2", 4'h0); sb_pop({3'b0, out0[1]});
    tick();
    sb_push("a_tog3", 4'h1); sb_pop({3'b0, out0[1]});

    // Under-length stream: FF toggles once on the IDLE edge then holds
    for (int k = 1; k <= 10; k++) begin
      if0.prog_en = 1'b1;
      if0.prog_in = k[0];
      tick();
      sb_push("short_hold", 4'h0); sb_pop({3'b0, out0[1]});
    end
    if0.prog_en = 1'b0;
    tick();
    chk("short_err_early", if0.prog_err, 0);
    tick();
    chk("short_err", {if1.prog_err, if0.prog_err}, 2'b11);
    chk("short_done", if0.prog_done, 0);
    chk("short_cfg_valid", if0.cfg_valid, 1);
    sb_push("short_hold_commit", 4'h0); sb_pop({3'b0, out0[1]});
    in0[3:0] = 4'hF; sb_push("short_and4_f", {3'b0, &in0[3:0]}); #1; sb_pop({3'b0, out0[0]});
    in0[3:0] = 4'h7; sb_push("short_and4_7", {3'b0, &in0[3:0]}); #1; sb_pop({3'b0, out0[0]});
    tick();
    chk("short_err_pulse", if0.prog_err, 0);
    sb_push("short_tog_resume", 4'h1); sb_pop({3'b0, out0[1]});

    // Two chained clusters, 152 bits
    in0 = '0;
    in1 = '0;
    load({img_b, img_c}, 152, 1'b1, "chain");
    in0[3:0] = 4'h7; sb_push("c_xor_7", {3'b0, ^in0[3:0]}); #1; sb_pop({3'b0, out0[0]});
    in0[3:0] = 4'h3; sb_push("c_xor_3", {3'b0, ^in0[3:0]}); #1; sb_pop({3'b0, out0[0]});
    sb_push("c_nor_0", {3'b0, ~|in1[3:0]}); sb_pop({3'b0, out1[0]});
    in1[3:0] = 4'h2; sb_push("c_nor_2", {3'b0, ~|in1[3:0]}); #1; sb_pop({3'b0, out1[0]});
    tick();
    chk("c_done_pulse", {if1.prog_done, if0.prog_done}, 2'b00);
    sb_push("c_en_off", 4'h0); sb_pop({3'b0, out0[3]});
    in0[15] = 1'b1;
    tick();
    sb_push("c_en_on", 4'h1); sb_pop({3'b0, out0[3]});

    // Reset in the middle of a load
    in0 = '0;
    for (int k = 0; k < 30; k++) begin
      if0.prog_en = 1'b1;
      if0.prog_in = 1'b1;
      tick();
    end
    rst = 1'b1;
    if0.prog_en = 1'b0;
    in0 = 16'hFFFF;
    in1 = 16'hFFFF;
    repeat (2) tick();
    chk("mid_cfg_valid", {if1.cfg_valid, if0.cfg_valid}, 2'b00);
    sb_push("mid_out0", 4'h0); sb_pop(out0);
    sb_push("mid_out1", 4'h0); sb_pop(out1);
    chk("mid_prog_out", if0.prog_out, 0);
    rst = 1'b0;
    in0 = '0;
    load({76'h0, img_a}, 76, 1'b1, "reload");
    chk("reload_cfg_valid", if0.cfg_valid, 1);
    in0[3:0] = 4'hF; sb_push("reload_and4", {3'b0, &in0[3:0]}); #1; sb_pop({3'b0, out0[0]});

    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
